// File: rtl/mem_port_arbiter.sv
// N-port round-robin memory request arbiter with read-tag remapping.
// One registered request per cycle; read responses are routed back by tag with the original ID.
module mem_port_arbiter #(
    parameter int unsigned NUM_PORTS  = 2,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ID_WIDTH   = 4
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic [NUM_PORTS-1:0]             port_valid_in,
    input  logic [NUM_PORTS*DATA_WIDTH-1:0]  port_addr_in,
    input  logic [NUM_PORTS*DATA_WIDTH-1:0]  port_data_in,
    input  logic [NUM_PORTS-1:0]             port_rw_in,
    input  logic [NUM_PORTS*ID_WIDTH-1:0]    port_id_in,
    output logic [NUM_PORTS-1:0]             port_stall_out,
    output logic [NUM_PORTS-1:0]             port_ready_out,
    output logic [DATA_WIDTH-1:0]            port_data_out,
    output logic [ID_WIDTH-1:0]              port_id_out,
    output logic [DATA_WIDTH-1:0]            mem_addr_out,
    output logic [DATA_WIDTH-1:0]            mem_data_out,
    output logic                             mem_rw_out,
    output logic [ID_WIDTH-1:0]              mem_id_out,
    output logic                             mem_valid_out,
    input  logic [DATA_WIDTH-1:0]            mem_data_in,
    input  logic [ID_WIDTH-1:0]              mem_id_in,
    input  logic                             mem_ready_in,
    input  logic                             mem_stall_in,
    output logic [ID_WIDTH:0]                outstanding_out,
    output logic                             err_out
);

    localparam int unsigned Depth = 1 << ID_WIDTH;
    localparam int unsigned PtrW  = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
    localparam int unsigned CntW  = ID_WIDTH + 1;

    logic [PtrW-1:0]       rr_q, rr_d;
    logic                  or_valid_q;
    logic [DATA_WIDTH-1:0] or_addr_q, or_data_q;
    logic                  or_rw_q;
    logic [ID_WIDTH-1:0]   or_id_q;

    logic [Depth-1:0]      tag_used_q, tag_used_d;
    logic [PtrW-1:0]       tag_port_q [Depth];
    logic [ID_WIDTH-1:0]   tag_oid_q  [Depth];

    logic [NUM_PORTS-1:0]  ready_q, ready_d;
    logic [DATA_WIDTH-1:0] rdata_q;
    logic [ID_WIDTH-1:0]   rid_q;
    logic                  err_q;
    logic [CntW-1:0]       outst_q, outst_d;

    logic [NUM_PORTS-1:0]  eligible;
    logic                  free_avail, grant_found, can_accept, accept, alloc, resp_hit;
    logic [PtrW-1:0]       grant_idx;
    logic [ID_WIDTH-1:0]   free_tag;
    logic [DATA_WIDTH-1:0] sel_addr, sel_data;
    logic                  sel_rw;
    logic [ID_WIDTH-1:0]   sel_id;

    // Lowest-index free tag, judged on the table state at the start of the cycle.
    always_comb begin
        free_tag = '0;
        for (int i = int'(Depth) - 1; i >= 0; i--) begin
            if (!tag_used_q[i]) free_tag = ID_WIDTH'(i);
        end
    end

    always_comb begin
        int unsigned idx;
        logic [PtrW-1:0] cand;
        free_avail = ~&tag_used_q;
        for (int unsigned p = 0; p < NUM_PORTS; p++) begin
            eligible[p] = port_valid_in[p] & (port_rw_in[p] | free_avail);
        end

        grant_found = 1'b0;
        grant_idx   = '0;
        for (int unsigned k = 0; k < NUM_PORTS; k++) begin
            idx = 32'(rr_q) + k;
            if (idx >= NUM_PORTS) idx = idx - NUM_PORTS;
            cand = PtrW'(idx);
            if (!grant_found && eligible[cand]) begin
                grant_found = 1'b1;
                grant_idx   = cand;
            end
        end

        can_accept = ~or_valid_q | ~mem_stall_in;
        accept     = grant_found & can_accept;

        port_stall_out = '1;
        if (accept) port_stall_out[grant_idx] = 1'b0;

        sel_addr = '0;
        sel_data = '0;
        sel_rw   = 1'b0;
        sel_id   = '0;
        for (int unsigned p = 0; p < NUM_PORTS; p++) begin
            if (PtrW'(p) == grant_idx) begin
                sel_addr = port_addr_in[p*DATA_WIDTH +: DATA_WIDTH];
                sel_data = port_data_in[p*DATA_WIDTH +: DATA_WIDTH];
                sel_rw   = port_rw_in[p];
                sel_id   = port_id_in[p*ID_WIDTH +: ID_WIDTH];
            end
        end
        alloc = accept & ~sel_rw;
    end

    always_comb begin
        resp_hit = mem_ready_in & tag_used_q[mem_id_in];
        ready_d  = '0;
        if (resp_hit) ready_d[tag_port_q[mem_id_in]] = 1'b1;

        // Free and alloc never target the same entry: one is in use, the other free.
        tag_used_d = tag_used_q;
        if (resp_hit) tag_used_d[mem_id_in] = 1'b0;
        if (alloc)    tag_used_d[free_tag]  = 1'b1;

        outst_d = outst_q + CntW'(alloc) - CntW'(resp_hit);

        rr_d = rr_q;
        if (accept) begin
            rr_d = (grant_idx == PtrW'(NUM_PORTS - 1)) ? '0 : grant_idx + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rr_q       <= '0;
            or_valid_q <= 1'b0;
            or_addr_q  <= '0;
            or_data_q  <= '0;
            or_rw_q    <= 1'b0;
            or_id_q    <= '0;
            tag_used_q <= '0;
            ready_q    <= '0;
            rdata_q    <= '0;
            rid_q      <= '0;
            err_q      <= 1'b0;
            outst_q    <= '0;
            for (int i = 0; i < int'(Depth); i++) begin
                tag_port_q[i] <= '0;
                tag_oid_q[i]  <= '0;
            end
        end else begin
            rr_q       <= rr_d;
            tag_used_q <= tag_used_d;
            outst_q    <= outst_d;
            ready_q    <= ready_d;

            if (accept) begin
                or_valid_q <= 1'b1;
                or_addr_q  <= sel_addr;
                or_data_q  <= sel_data;
                or_rw_q    <= sel_rw;
                or_id_q    <= sel_rw ? '0 : free_tag;
            end else if (or_valid_q && !mem_stall_in) begin
                or_valid_q <= 1'b0;
            end

            if (alloc) begin
                tag_port_q[free_tag] <= grant_idx;
                tag_oid_q[free_tag]  <= sel_id;
            end

            if (resp_hit) begin
                rdata_q <= mem_data_in;
                rid_q   <= tag_oid_q[mem_id_in];
            end
            if (mem_ready_in && !tag_used_q[mem_id_in]) err_q <= 1'b1;
        end
    end

    assign mem_valid_out   = or_valid_q;
    assign mem_addr_out    = or_addr_q;
    assign mem_data_out    = or_data_q;
    assign mem_rw_out      = or_rw_q;
    assign mem_id_out      = or_id_q;
    assign port_ready_out  = ready_q;
    assign port_data_out   = rdata_q;
    assign port_id_out     = rid_q;
    assign outstanding_out = outst_q;
    assign err_out         = err_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed table, hand sequences and random traffic
// checked against a transaction-level tag-table model.
module tb_mem_port_arbiter;

    localparam int N     = 2;
    localparam int DW    = 32;
    localparam int IW    = 4;
    localparam int DEPTH = 16;

    logic            clk, reset;
    logic [N-1:0]    pv, prw;
    logic [N*DW-1:0] paddr, pdata;
    logic [N*IW-1:0] pid;
    logic [N-1:0]    stall, rdy;
    logic [DW-1:0]   pdout, maddr, mdout, mdin;
    logic [IW-1:0]   pidout, mid, midin;
    logic            mrw, mvalid, mready, mstall, err;
    logic [IW:0]     outst;

    mem_port_arbiter #(.NUM_PORTS(N), .DATA_WIDTH(DW), .ID_WIDTH(IW)) dut (
        .clk(clk), .reset(reset),
        .port_valid_in(pv), .port_addr_in(paddr), .port_data_in(pdata),
        .port_rw_in(prw), .port_id_in(pid),
        .port_stall_out(stall), .port_ready_out(rdy),
        .port_data_out(pdout), .port_id_out(pidout),
        .mem_addr_out(maddr), .mem_data_out(mdout), .mem_rw_out(mrw),
        .mem_id_out(mid), .mem_valid_out(mvalid),
        .mem_data_in(mdin), .mem_id_in(midin), .mem_ready_in(mready),
        .mem_stall_in(mstall), .outstanding_out(outst), .err_out(err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference model: tag table as arrays, one pending memory request, last response.
    bit          m_used [DEPTH];
    int          m_port [DEPTH];
    int          m_oid  [DEPTH];
    int          m_rr;
    bit          m_orv, m_orrw, m_err;
    logic [31:0] m_ora, m_ord, m_pdata;
    int          m_orid, m_pid;
    logic [1:0]  m_rdy;

    function automatic int m_count();
        int c = 0;
        for (int i = 0; i < DEPTH; i++) c += int'(m_used[i]);
        return c;
    endfunction

    function automatic int m_grant();
        for (int k = 0; k < N; k++) begin
            int p;
            p = (m_rr + k) % N;
            if (pv[p] && (prw[p] || m_count() < DEPTH)) return p;
        end
        return -1;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < DEPTH; i++) begin
            m_used[i] = 1'b0;
            m_port[i] = 0;
            m_oid[i]  = 0;
        end
        m_rr = 0; m_orv = 0; m_orrw = 0; m_err = 0;
        m_ora = '0; m_ord = '0; m_pdata = '0; m_orid = 0; m_pid = 0; m_rdy = '0;
    endtask

    task automatic model_step();
        int g, lf;
        bit acc;
        g   = m_grant();
        acc = (g >= 0) && (!m_orv || !mstall);
        lf  = -1;
        for (int i = DEPTH - 1; i >= 0; i--) if (!m_used[i]) lf = i;
        m_rdy = '0;
        if (mready) begin
            if (m_used[midin]) begin
                m_rdy         = 2'(1 << m_port[midin]);
                m_pdata       = mdin;
                m_pid         = m_oid[midin];
                m_used[midin] = 1'b0;
            end else begin
                m_err = 1'b1;
            end
        end
        if (acc) begin
            m_orv  = 1'b1;
            m_ora  = paddr[g*DW +: DW];
            m_ord  = pdata[g*DW +: DW];
            m_orrw = prw[g];
            m_orid = 0;
            if (!prw[g]) begin
                m_used[lf] = 1'b1;
                m_port[lf] = g;
                m_oid[lf]  = int'(pid[g*IW +: IW]);
                m_orid     = lf;
            end
            m_rr = (g + 1) % N;
        end else if (m_orv && !mstall) begin
            m_orv = 1'b0;
        end
    endtask

    task automatic check_all(input string t);
        int g;
        bit acc;
        logic [1:0] es;
        g   = m_grant();
        acc = (g >= 0) && (!m_orv || !mstall);
        es  = 2'b11;
        if (acc) es[g] = 1'b0;
        chk({t, " stall"}, 64'(stall), 64'(es));
        chk({t, " mem_valid"}, 64'(mvalid), 64'(m_orv));
        if (m_orv) begin
            chk({t, " mem_addr"}, 64'(maddr), 64'(m_ora));
            chk({t, " mem_rw"}, 64'(mrw), 64'(m_orrw));
            chk({t, " mem_id"}, 64'(mid), 64'(m_orid));
            if (m_orrw) chk({t, " mem_data"}, 64'(mdout), 64'(m_ord));
        end
        chk({t, " ready"}, 64'(rdy), 64'(m_rdy));
        if (m_rdy != 0) begin
            chk({t, " rdata"}, 64'(pdout), 64'(m_pdata));
            chk({t, " rid"}, 64'(pidout), 64'(m_pid));
        end
        chk({t, " outstanding"}, 64'(outst), 64'(m_count()));
        chk({t, " err"}, 64'(err), 64'(m_err));
    endtask

    // Inputs are set at a falling edge; outputs are checked 1 time unit later.
    task automatic tick(input string t);
        #1;
        check_all(t);
        model_step();
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        pv = '0; prw = '0; mready = 1'b0; mstall = 1'b0; midin = '0; mdin = '0;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        model_reset();
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
    endtask

    typedef struct {
        logic [1:0]  pv, prw;
        bit          mstall, mready;
        logic [3:0]  mid;
        logic [31:0] mdin;
        logic [1:0]  e_stall;
        bit          e_mvalid;
        logic [3:0]  e_mid;
        int          e_out;
        logic [1:0]  e_rdy;
    } vec_t;

    vec_t tbl [12];

    initial begin
        int n;
        reset = 1'b0;
        idle_inputs();
        paddr = {32'h2000_0000, 32'h1000_0000};
        pdata = {32'hD1D1_D1D1, 32'hD0D0_D0D0};
        pid   = {4'd2, 4'd1};

        // Alternating reads from both ports, then tags 2,0,1,3 returned out of order.
        tbl[0]  = '{2'b11, 2'b00, 0, 0, 4'd0, 32'h0, 2'b10, 0, 4'd0, 0, 2'b00};
        tbl[1]  = '{2'b11, 2'b00, 0, 0, 4'd0, 32'h0, 2'b01, 1, 4'd0, 1, 2'b00};
        tbl[2]  = '{2'b11, 2'b00, 0, 0, 4'd0, 32'h0, 2'b10, 1, 4'd1, 2, 2'b00};
        tbl[3]  = '{2'b11, 2'b00, 0, 0, 4'd0, 32'h0, 2'b01, 1, 4'd2, 3, 2'b00};
        tbl[4]  = '{2'b00, 2'b00, 0, 0, 4'd0, 32'h0, 2'b11, 1, 4'd3, 4, 2'b00};
        tbl[5]  = '{2'b00, 2'b00, 0, 0, 4'd0, 32'h0, 2'b11, 0, 4'd0, 4, 2'b00};
        tbl[6]  = '{2'b00, 2'b00, 0, 1, 4'd2, 32'hA, 2'b11, 0, 4'd0, 4, 2'b00};
        tbl[7]  = '{2'b00, 2'b00, 0, 1, 4'd0, 32'hB, 2'b11, 0, 4'd0, 3, 2'b01};
        tbl[8]  = '{2'b00, 2'b00, 0, 1, 4'd1, 32'hC, 2'b11, 0, 4'd0, 2, 2'b01};
        tbl[9]  = '{2'b00, 2'b00, 0, 1, 4'd3, 32'hD, 2'b11, 0, 4'd0, 1, 2'b10};
        tbl[10] = '{2'b00, 2'b00, 0, 0, 4'd0, 32'h0, 2'b11, 0, 4'd0, 0, 2'b10};
        tbl[11] = '{2'b00, 2'b00, 0, 0, 4'd0, 32'h0, 2'b11, 0, 4'd0, 0, 2'b00};

        do_reset();
        #1;
        chk("reset mem_valid", 64'(mvalid), 64'(0));
        chk("reset outstanding", 64'(outst), 64'(0));

        for (int i = 0; i < 12; i++) begin
            pv = tbl[i].pv; prw = tbl[i].prw; mstall = tbl[i].mstall;
            mready = tbl[i].mready; midin = tbl[i].mid; mdin = tbl[i].mdin;
            #1;
            chk($sformatf("tbl%0d stall", i), 64'(stall), 64'(tbl[i].e_stall));
            chk($sformatf("tbl%0d mem_valid", i), 64'(mvalid), 64'(tbl[i].e_mvalid));
            if (tbl[i].e_mvalid) chk($sformatf("tbl%0d mem_id", i), 64'(mid), 64'(tbl[i].e_mid));
            chk($sformatf("tbl%0d outstanding", i), 64'(outst), 64'(tbl[i].e_out));
            chk($sformatf("tbl%0d ready", i), 64'(rdy), 64'(tbl[i].e_rdy));
            tick($sformatf("tbl%0d", i));
        end

        // Same-cycle free of tag 0 and new read: new read must take tag 1.
        idle_inputs();
        pv = 2'b01; pid = {4'd9, 4'd7};
        tick("s6a");
        pv = 2'b10; mready = 1'b1; midin = 4'd0; mdin = 32'h55;
        tick("s6b");
        idle_inputs();
        #1;
        chk("s6 new tag", 64'(mid), 64'(1));
        chk("s6 outstanding", 64'(outst), 64'(1));
        chk("s6 ready", 64'(rdy), 64'(2'b01));
        mready = 1'b1; midin = 4'd1; mdin = 32'h66;
        tick("s6c");
        idle_inputs();

        // Memory stalled 3 cycles: request held, port 0 stalled, then issue.
        paddr = {32'h0000_0100, 32'h0000_0200}; pid = {4'd5, 4'd3};
        pv = 2'b10;
        tick("s3a");
        pv = 2'b01; mstall = 1'b1;
        for (int c = 0; c < 3; c++) begin
            #1;
            chk($sformatf("s3 hold addr c%0d", c), 64'(maddr), 64'(32'h100));
            chk($sformatf("s3 p0 stalled c%0d", c), 64'(stall[0]), 64'(1));
            tick($sformatf("s3 stall%0d", c));
        end
        mstall = 1'b0;
        #1;
        chk("s3 p0 accepted", 64'(stall[0]), 64'(0));
        tick("s3 release");
        pv = 2'b00;
        #1;
        chk("s3 next addr", 64'(maddr), 64'(32'h200));
        tick("s3 drain");

        // Fill the tag table, then a read stalls while a write goes through.
        pv = 2'b11; prw = 2'b00;
        n = 0;
        while (m_count() < DEPTH && n < 40) begin
            tick($sformatf("s4 fill%0d", n));
            n++;
        end
        #1;
        chk("s4 outstanding full", 64'(outst), 64'(DEPTH));
        pdata = {32'hBBBB_0001, 32'hCAFE_F00D};
        prw = 2'b01;
        #1;
        chk("s4 write granted", 64'(stall), 64'(2'b10));
        tick("s4 write");
        pv = 2'b11; prw = 2'b00;
        #1;
        chk("s4 write rw", 64'(mrw), 64'(1));
        chk("s4 write id", 64'(mid), 64'(0));
        chk("s4 write data", 64'(mdout), 64'(32'hCAFE_F00D));

        // Reset in the middle of traffic; a late response to old tag 3 is an error.
        reset = 1'b0;
        #1;
        chk("s1 mem_valid", 64'(mvalid), 64'(0));
        chk("s1 mem_addr", 64'(maddr), 64'(0));
        chk("s1 mem_data", 64'(mdout), 64'(0));
        chk("s1 mem_rw", 64'(mrw), 64'(0));
        chk("s1 mem_id", 64'(mid), 64'(0));
        chk("s1 ready", 64'(rdy), 64'(0));
        chk("s1 rdata", 64'(pdout), 64'(0));
        chk("s1 rid", 64'(pidout), 64'(0));
        chk("s1 outstanding", 64'(outst), 64'(0));
        chk("s1 err", 64'(err), 64'(0));
        model_reset();
        @(negedge clk);
        reset = 1'b1;
        idle_inputs();
        mready = 1'b1; midin = 4'd3; mdin = 32'h77;
        tick("s1 resp");
        mready = 1'b0;
        #1;
        chk("s1 no strobe", 64'(rdy), 64'(0));
        chk("s1 err set", 64'(err), 64'(1));
        tick("s1 after");

        // Random traffic against the model.
        do_reset();
        for (int c = 0; c < 500; c++) begin
            pv     = 2'($urandom);
            prw    = 2'($urandom);
            paddr  = {$urandom, $urandom};
            pdata  = {$urandom, $urandom};
            pid    = 8'($urandom);
            mstall = ($urandom_range(0, 9) < 3);
            mready = ($urandom_range(0, 9) < 4);
            mdin   = $urandom;
            midin  = 4'($urandom);
            if (m_count() > 0 && $urandom_range(0, 9) < 8) begin
                int s;
                s = $urandom_range(0, DEPTH - 1);
                for (int k = 0; k < DEPTH; k++) begin
                    if (!m_used[midin]) midin = 4'((s + k) % DEPTH);
                end
            end
            tick($sformatf("rnd%0d", c));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
